// File: rtl/vram_arbiter.sv
// Shares one single-port VRAM between a pulsed video fetcher and a level-handshaked CPU.
// Video has priority; a started access always runs MEM_LAT edges and back-to-back accesses chain.
module vram_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  output logic [15:0] vid_data,
  output logic        vid_valid,
  output logic        vid_ovf,
  input  logic        vid_ovf_clr,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_wtbt,
  input  logic [13:0] cpu_addr,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_ack,
  output logic [13:0] mem_addr,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_VID  = 2'd1;
  localparam logic [1:0] S_CPU  = 2'd2;

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic        vid_pend;
  logic        cpu_armed;
  logic [13:0] vid_addr_q;

  logic        capture, vid_cap, cpu_cap, free;
  logic        pend_kept, vid_any, cpu_go;
  logic [13:0] vid_start_addr;

  always_comb begin
    capture        = (state != S_IDLE) && (cnt == 3'(MEM_LAT));
    vid_cap        = capture && (state == S_VID);
    cpu_cap        = capture && (state == S_CPU);
    free           = (state == S_IDLE) || capture;
    // The pending flag covers the whole video access and drops only at its capture edge.
    pend_kept      = vid_pend && !vid_cap;
    vid_any        = pend_kept || vid_req;
    vid_start_addr = pend_kept ? vid_addr_q : vid_addr;
    cpu_go         = cpu_req && cpu_armed && !cpu_cap;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      vid_pend   <= 1'b0;
      vid_ovf    <= 1'b0;
      cpu_armed  <= 1'b1;
      vid_addr_q <= 14'd0;
      vid_valid  <= 1'b0;
      cpu_ack    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 14'd0;
      mem_be     <= 2'b00;
      mem_din    <= 16'd0;
      vid_data   <= 16'd0;
      cpu_dout   <= 16'd0;
    end else begin
      vid_valid <= 1'b0;
      cpu_ack   <= 1'b0;

      if (vid_cap) begin
        vid_data  <= mem_dout;
        vid_valid <= 1'b1;
      end
      if (cpu_cap) begin
        cpu_ack <= 1'b1;
        if (!mem_we) cpu_dout <= mem_dout;
      end

      if (vid_req && !pend_kept) begin
        vid_pend   <= 1'b1;
        vid_addr_q <= vid_addr;
      end else if (vid_cap) begin
        vid_pend <= 1'b0;
      end

      if (vid_req && pend_kept) vid_ovf <= 1'b1;
      else if (vid_ovf_clr)     vid_ovf <= 1'b0;

      // Disarm at ack so a still-held request is not served twice.
      if (cpu_cap)       cpu_armed <= 1'b0;
      else if (!cpu_req) cpu_armed <= 1'b1;

      if (free && vid_any) begin
        state    <= S_VID;
        cnt      <= 3'd1;
        mem_addr <= vid_start_addr;
        mem_we   <= 1'b0;
        mem_be   <= 2'b11;
        mem_din  <= cpu_din;
      end else if (free && cpu_go) begin
        state    <= S_CPU;
        cnt      <= 3'd1;
        mem_addr <= cpu_addr;
        mem_we   <= cpu_we;
        mem_be   <= cpu_we ? cpu_wtbt : 2'b11;
        mem_din  <= cpu_din;
      end else if (capture) begin
        state  <= S_IDLE;
        cnt    <= 3'd0;
        mem_we <= 1'b0;
      end else if (state != S_IDLE) begin
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a RAM model that returns data exactly MEM_LAT edges after the address.
module tb_vram_arbiter;
  localparam int MEM_LAT = 2;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        vid_req, vid_ovf_clr, cpu_req, cpu_we;
  logic [13:0] vid_addr, cpu_addr;
  logic [1:0]  cpu_wtbt;
  logic [15:0] cpu_din;
  logic [15:0] vid_data, cpu_dout, mem_din, mem_dout;
  logic        vid_valid, vid_ovf, cpu_ack, mem_we;
  logic [13:0] mem_addr;
  logic [1:0]  mem_be;

  int checks = 0;
  int passed = 0;

  logic [15:0] ram [0:16383];
  logic [13:0] addr_d;

  always #5 clk_sys = ~clk_sys;

  vram_arbiter #(.MEM_LAT(MEM_LAT)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_valid(vid_valid), .vid_ovf(vid_ovf), .vid_ovf_clr(vid_ovf_clr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_wtbt(cpu_wtbt), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // One address register gives data at the second edge after the address edge.
  always @(posedge clk_sys) begin
    addr_d <= mem_addr;
    if (mem_we) begin
      if (mem_be[0]) ram[mem_addr][7:0]  <= mem_din[7:0];
      if (mem_be[1]) ram[mem_addr][15:8] <= mem_din[15:8];
    end
  end
  assign mem_dout = ram[addr_d];

  function automatic logic [15:0] iv(input logic [13:0] a);
    return {2'b00, a} ^ 16'hC3A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    int acks;
    int wes;
    for (int a = 0; a < 16384; a++) ram[a] = iv(14'(a));
    ram[14'h0123] = 16'hBEEF;
    addr_d = 14'd0;
    reset = 1'b1; vid_req = 0; vid_ovf_clr = 0; cpu_req = 0; cpu_we = 0;
    vid_addr = 0; cpu_addr = 0; cpu_wtbt = 0; cpu_din = 0;
    tick(); tick();
    chk("rst_outputs", {vid_valid, vid_ovf, cpu_ack, mem_we, mem_be}, 32'd0);
    chk("rst_data", {vid_data, cpu_dout}, 32'd0);
    chk("rst_mem", {mem_addr, mem_din}, 32'd0);
    reset = 1'b0;
    tick();

    // Video read with no contention
    vid_req = 1; vid_addr = 14'h0123;
    tick();
    vid_req = 0;
    chk("vid_addr_e0", mem_addr, 14'h0123);
    tick();
    chk("vid_valid_e1", vid_valid, 0);
    tick();
    chk("vid_valid_e2", vid_valid, 1);
    chk("vid_data", vid_data, 16'hBEEF);
    tick();
    chk("vid_valid_pulse", vid_valid, 0);

    // CPU low-byte write with request held afterwards
    cpu_req = 1; cpu_we = 1; cpu_wtbt = 2'b01; cpu_addr = 14'h0010; cpu_din = 16'hA55A;
    tick();
    chk("wr_e0_strobe", {mem_we, mem_be, mem_addr, mem_din}, {1'b1, 2'b01, 14'h0010, 16'hA55A});
    chk("wr_e0_ack", cpu_ack, 0);
    tick();
    chk("wr_e1_we", mem_we, 1);
    tick();
    chk("wr_e2_we", mem_we, 0);
    chk("wr_e2_ack", cpu_ack, 1);
    acks = 0; wes = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      acks += int'(cpu_ack);
      wes  += int'(mem_we);
    end
    chk("wr_held_no_reack", acks, 0);
    chk("wr_held_no_we", wes, 0);
    chk("wr_ram", ram[14'h0010], {iv(14'h0010) >> 8, 8'h5A});
    cpu_req = 0; cpu_we = 0;
    tick();

    // Simultaneous CPU read and video request
    cpu_req = 1; cpu_addr = 14'h0020; vid_req = 1; vid_addr = 14'h0030;
    tick();
    vid_req = 0;
    chk("both_e0_vid_first", mem_addr, 14'h0030);
    tick();
    tick();
    chk("both_e2_vid_valid", vid_valid, 1);
    chk("both_e2_vid_data", vid_data, iv(14'h0030));
    chk("both_e2_cpu_chain", {cpu_ack, mem_we, mem_addr}, {1'b0, 1'b0, 14'h0020});
    tick();
    chk("both_e3_ack", cpu_ack, 0);
    tick();
    chk("both_e4_ack", cpu_ack, 1);
    chk("both_e4_dout", cpu_dout, iv(14'h0020));
    cpu_req = 0;
    tick();

    // Two video requests during a CPU read
    cpu_req = 1; cpu_addr = 14'h0040;
    tick();
    chk("ovf_cpu_start", mem_addr, 14'h0040);
    vid_req = 1; vid_addr = 14'h0050;
    tick();
    chk("ovf_first_ok", vid_ovf, 0);
    vid_addr = 14'h0060;
    tick();
    vid_req = 0; cpu_req = 0;
    chk("ovf_set", vid_ovf, 1);
    chk("ovf_cpu_ack", cpu_ack, 1);
    chk("ovf_vid_chain", mem_addr, 14'h0050);
    tick();
    tick();
    chk("ovf_vid_valid", vid_valid, 1);
    chk("ovf_vid_data_first", vid_data, iv(14'h0050));
    vid_ovf_clr = 1;
    tick();
    vid_ovf_clr = 0;
    chk("ovf_clr", vid_ovf, 0);

    // Clear coinciding with a new overflow: set wins
    vid_req = 1; vid_addr = 14'h0100;
    tick();
    vid_ovf_clr = 1;
    tick();
    vid_req = 0;
    chk("ovf_set_beats_clr", vid_ovf, 1);
    tick();
    vid_ovf_clr = 0;
    chk("ovf_clr_again", vid_ovf, 0);
    tick(); tick();

    // Reset one cycle into a CPU read with the request held
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0070;
    tick();
    chk("rstmid_start", mem_addr, 14'h0070);
    reset = 1;
    tick();
    chk("rstmid_abort", {cpu_ack, mem_we, mem_addr}, 32'd0);
    tick();
    chk("rstmid_no_ack", cpu_ack, 0);
    reset = 0;
    acks = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (cpu_ack) begin
        acks++;
        chk("rstmid_dout", cpu_dout, iv(14'h0070));
      end
    end
    chk("rstmid_ack_once", acks, 1);
    cpu_req = 0;
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
